// File: rtl/tone_pkg.sv
// Shared constants and types for the single-counter tone generator.
// Period table holds 100 MHz clock counts for each note, before any shift.
package tone_pkg;

  localparam int TONE_TABLE_LEN = 12;
  localparam int MAX_DUTY       = 100;

  localparam logic [31:0] TONE_PERIOD [TONE_TABLE_LEN] = '{
    32'd381678, 32'd340136, 32'd303030, 32'd286532,
    32'd255102, 32'd227272, 32'd202428, 32'd191204,
    32'd170358, 32'd151744, 32'd143266, 32'd127550
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tone_gen_shared_thresh.sv
// Combinational note lookup: period for a sel code and the high-time threshold
// for a duty in percent (clamped to 100), multiplied at full width before the divide.
module tone_thresh
  import tone_pkg::*;
#(
  parameter int N_TONES      = 12,
  parameter int SEL_W        = 4,
  parameter int CNT_W        = 19,
  parameter int DUTY_W       = 7,
  parameter int PERIOD_SHIFT = 0
) (
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [DUTY_W-1:0] duty_i,
  output logic              valid_o,
  output logic [CNT_W-1:0]  period_o,
  output logic [CNT_W-1:0]  high_o
);

  localparam int PROD_W = CNT_W + DUTY_W;

  logic [DUTY_W-1:0] duty_c;
  logic [PROD_W-1:0] prod;

  always_comb begin
    valid_o  = (sel_i != '0) && (sel_i <= SEL_W'(N_TONES));
    period_o = '0;
    // Matching sel against k+1 avoids ever forming sel-1 for an invalid code.
    for (int k = 0; k < TONE_TABLE_LEN; k++) begin
      if (valid_o && (k < N_TONES) && (sel_i == SEL_W'(k + 1))) begin
        period_o = CNT_W'(TONE_PERIOD[k] >> PERIOD_SHIFT);
      end
    end
    duty_c = (duty_i > DUTY_W'(MAX_DUTY)) ? DUTY_W'(MAX_DUTY) : duty_i;
    prod   = PROD_W'(period_o) * PROD_W'(duty_c);
    high_o = CNT_W'(prod / PROD_W'(MAX_DUTY));
  end

endmodule

// File: rtl/tone_gen_shared.sv
// Tone generator with one shared period counter; note and duty are resampled only
// at period boundaries so tone_clk never glitches. All outputs are registered.
module tone_gen_shared
  import tone_pkg::*;
#(
  parameter int N_TONES      = 12,
  parameter int SEL_W        = 4,
  parameter int CNT_W        = 19,
  parameter int DUTY_W       = 7,
  parameter int PERIOD_SHIFT = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [SEL_W-1:0]  key_pad,
  input  logic [DUTY_W-1:0] duty_cycle,
  output logic              tone_clk,
  output logic              busy,
  output logic              note_start,
  output logic [SEL_W-1:0]  note_idx
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic              tone_q, tone_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;

  logic              th_valid;
  logic [CNT_W-1:0]  th_period;
  logic [CNT_W-1:0]  th_high;
  logic              boundary;

  tone_thresh #(
    .N_TONES      (N_TONES),
    .SEL_W        (SEL_W),
    .CNT_W        (CNT_W),
    .DUTY_W       (DUTY_W),
    .PERIOD_SHIFT (PERIOD_SHIFT)
  ) u_thresh (
    .sel_i    (key_pad),
    .duty_i   (duty_cycle),
    .valid_o  (th_valid),
    .period_o (th_period),
    .high_o   (th_high)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      idx_q    <= '0;
      tone_q   <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      idx_q    <= idx_d;
      tone_q   <= tone_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
    end
  end

  // IDLE samples every cycle; RUN samples only on the last count of the period.
  assign boundary = (state_q == IDLE) || (cnt_q == period_q - CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    high_d   = high_q;
    idx_d    = idx_q;
    if (!boundary) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (th_valid) begin
      state_d  = RUN;
      cnt_d    = '0;
      period_d = th_period;
      high_d   = th_high;
      idx_d    = key_pad;
    end else begin
      state_d  = IDLE;
      cnt_d    = '0;
      period_d = '0;
      high_d   = '0;
      idx_d    = '0;
    end
  end

  // Outputs are derived from next-state so they align with the registered cnt.
  always_comb begin
    busy_d  = (state_d == RUN);
    start_d = (state_d == RUN) && (cnt_d == '0);
    tone_d  = (state_d == RUN) && (cnt_d < high_d);
  end

  assign tone_clk   = tone_q;
  assign busy       = busy_q;
  assign note_start = start_q;
  assign note_idx   = idx_q;

endmodule

// File: tb/tb_tone_gen_shared.sv
// Directed bench for tone_gen_shared with PERIOD_SHIFT=12 (tones 1,2,3,12 -> 93,83,73,31 cycles).
module tb_tone_gen_shared;

  localparam int SEL_W  = 4;
  localparam int DUTY_W = 7;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [SEL_W-1:0]  key_pad = '0;
  logic [DUTY_W-1:0] duty_cycle = '0;
  logic              tone_clk;
  logic              busy;
  logic              note_start;
  logic [SEL_W-1:0]  note_idx;

  int vectors = 0;
  int miscompares = 0;

  tone_gen_shared #(
    .N_TONES      (12),
    .SEL_W        (SEL_W),
    .CNT_W        (19),
    .DUTY_W       (DUTY_W),
    .PERIOD_SHIFT (12)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_pad    (key_pad),
    .duty_cycle (duty_cycle),
    .tone_clk   (tone_clk),
    .busy       (busy),
    .note_start (note_start),
    .note_idx   (note_idx)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Observes len cycles starting at the current one; hi_end is last high index + 1.
  task automatic run_period(input int len, output int hi, output int hi_end,
                            output int starts, output logic [SEL_W-1:0] last_idx);
    hi = 0; hi_end = 0; starts = 0; last_idx = '0;
    for (int i = 0; i < len; i++) begin
      if (tone_clk) begin
        hi++;
        hi_end = i + 1;
      end
      if (note_start) starts++;
      last_idx = note_idx;
      step();
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; key_pad = 4'd1; duty_cycle = 7'd50;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({tone_clk, busy, note_start, note_idx} !== 7'd0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 0000000", i, {tone_clk, busy, note_start, note_idx});
      end
    end
    sys_rst = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL release_busy: got %b expected 1", busy); end
    vectors++;
    if (note_idx !== 4'd1) begin miscompares++; $display("FAIL release_idx: got %0d expected 1", note_idx); end
    vectors++;
    if (note_start !== 1'b1) begin miscompares++; $display("FAIL release_start: got %b expected 1", note_start); end
    vectors++;
    if (tone_clk !== 1'b1) begin miscompares++; $display("FAIL release_tone: got %b expected 1", tone_clk); end
  endtask

  task automatic test_duty50();
    int hi, hi_end, st;
    logic [SEL_W-1:0] idx;
    run_period(93, hi, hi_end, st, idx);
    vectors++;
    if (hi !== 46) begin miscompares++; $display("FAIL duty50_high: got %0d expected 46", hi); end
    vectors++;
    if (hi_end !== 46) begin miscompares++; $display("FAIL duty50_contig: got %0d expected 46", hi_end); end
    vectors++;
    if (st !== 1) begin miscompares++; $display("FAIL duty50_starts: got %0d expected 1", st); end
    vectors++;
    if (note_start !== 1'b1) begin miscompares++; $display("FAIL duty50_next_start: got %b expected 1", note_start); end
  endtask

  task automatic test_change_sel();
    int hi1, hi2, e, st1, st2;
    logic [SEL_W-1:0] idx;
    run_period(20, hi1, e, st1, idx);
    key_pad = 4'd2;
    run_period(73, hi2, e, st2, idx);
    vectors++;
    if (hi1 + hi2 !== 46) begin miscompares++; $display("FAIL chg_old_high: got %0d expected 46", hi1 + hi2); end
    vectors++;
    if (st1 + st2 !== 1) begin miscompares++; $display("FAIL chg_old_starts: got %0d expected 1", st1 + st2); end
    vectors++;
    if (idx !== 4'd1) begin miscompares++; $display("FAIL chg_old_idx: got %0d expected 1", idx); end
    vectors++;
    if ({note_start, note_idx} !== 5'b1_0010) begin miscompares++; $display("FAIL chg_new_start_idx: got %b expected 10010", {note_start, note_idx}); end
    run_period(83, hi1, e, st1, idx);
    vectors++;
    if (hi1 !== 41 || e !== 41) begin miscompares++; $display("FAIL chg_new_high: got %0d/%0d expected 41/41", hi1, e); end
    vectors++;
    if (st1 !== 1 || note_start !== 1'b1) begin miscompares++; $display("FAIL chg_new_len: got starts %0d next %b expected 1 1", st1, note_start); end
  endtask

  task automatic test_duty_extremes();
    int hi, hi2, e, st, st2;
    logic [SEL_W-1:0] idx;
    key_pad = 4'd12; duty_cycle = 7'd0;
    run_period(83, hi, e, st, idx);
    vectors++;
    if (hi !== 41) begin miscompares++; $display("FAIL ignore_midperiod: got %0d expected 41", hi); end
    vectors++;
    if ({note_idx, note_start, tone_clk} !== 6'b1100_1_0) begin miscompares++; $display("FAIL duty0_first: got %b expected 110010", {note_idx, note_start, tone_clk}); end
    run_period(10, hi, e, st, idx);
    duty_cycle = 7'd100;
    run_period(21, hi2, e, st2, idx);
    vectors++;
    if (hi + hi2 !== 0) begin miscompares++; $display("FAIL duty0_high: got %0d expected 0", hi + hi2); end
    vectors++;
    if (st + st2 !== 1 || busy !== 1'b1) begin miscompares++; $display("FAIL duty0_start_busy: got %0d %b expected 1 1", st + st2, busy); end
    run_period(31, hi, e, st, idx);
    vectors++;
    if (hi !== 31) begin miscompares++; $display("FAIL duty100_high: got %0d expected 31", hi); end
    vectors++;
    if (note_start !== 1'b1) begin miscompares++; $display("FAIL duty100_len: got %b expected 1", note_start); end
  endtask

  task automatic test_clamp();
    int hi, e, st;
    logic [SEL_W-1:0] idx;
    duty_cycle = 7'd127;
    run_period(31, hi, e, st, idx);
    run_period(31, hi, e, st, idx);
    vectors++;
    if (hi !== 31 || st !== 1) begin miscompares++; $display("FAIL clamp127: got high %0d starts %0d expected 31 1", hi, st); end
    vectors++;
    if (note_start !== 1'b1) begin miscompares++; $display("FAIL clamp127_len: got %b expected 1", note_start); end
  endtask

  task automatic test_stop();
    int hi, e, st;
    logic [SEL_W-1:0] idx;
    key_pad = 4'd0;
    run_period(31, hi, e, st, idx);
    vectors++;
    if (hi !== 31) begin miscompares++; $display("FAIL stop0_tail: got %0d expected 31", hi); end
    vectors++;
    if ({tone_clk, busy, note_start, note_idx} !== 7'd0) begin miscompares++; $display("FAIL stop0_idle: got %b expected 0000000", {tone_clk, busy, note_start, note_idx}); end
    for (int i = 0; i < 5; i++) step();
    key_pad = 4'd13;
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if ({busy, note_idx} !== 5'd0) begin miscompares++; $display("FAIL idle13_stays: got %b expected 00000", {busy, note_idx}); end
    key_pad = 4'd12; duty_cycle = 7'd50;
    step();
    vectors++;
    if ({busy, note_idx} !== 5'b1_1100) begin miscompares++; $display("FAIL restart12: got %b expected 11100", {busy, note_idx}); end
    key_pad = 4'd13;
    run_period(31, hi, e, st, idx);
    vectors++;
    if (hi !== 15 || e !== 15) begin miscompares++; $display("FAIL stop13_high: got %0d/%0d expected 15/15", hi, e); end
    vectors++;
    if ({tone_clk, busy, note_idx} !== 6'd0) begin miscompares++; $display("FAIL stop13_idle: got %b expected 000000", {tone_clk, busy, note_idx}); end
  endtask

  task automatic test_reset_mid();
    int hi, e, st;
    logic [SEL_W-1:0] idx;
    key_pad = 4'd3; duty_cycle = 7'd50;
    step();
    run_period(50, hi, e, st, idx);
    sys_rst = 1'b1;
    step();
    vectors++;
    if ({tone_clk, busy, note_start, note_idx} !== 7'd0) begin miscompares++; $display("FAIL reset_mid: got %b expected 0000000", {tone_clk, busy, note_start, note_idx}); end
    sys_rst = 1'b0;
    step();
    vectors++;
    if ({busy, note_start, note_idx} !== 6'b11_0011) begin miscompares++; $display("FAIL reset_mid_restart: got %b expected 110011", {busy, note_start, note_idx}); end
    run_period(73, hi, e, st, idx);
    vectors++;
    if (hi !== 36 || e !== 36 || st !== 1) begin miscompares++; $display("FAIL tone3_period: got %0d/%0d/%0d expected 36/36/1", hi, e, st); end
    vectors++;
    if (note_start !== 1'b1) begin miscompares++; $display("FAIL tone3_len: got %b expected 1", note_start); end
  endtask

  initial begin
    test_reset();
    test_duty50();
    test_change_sel();
    test_duty_extremes();
    test_clamp();
    test_stop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
